// File: rtl/uart_mem_ctrl.sv
// Command parser between the UART byte streams and a 256-byte synchronous RAM.
// Frames are CMD, ADDR, LEN (0 means 256), then LEN data bytes for a write burst.
module uart_mem_ctrl #(
  parameter int unsigned AddrW   = 8,
  parameter logic [7:0]  CmdWr   = 8'h57,
  parameter logic [7:0]  CmdRd   = 8'h52,
  parameter logic [7:0]  AckByte = 8'h06,
  parameter logic [7:0]  NakByte = 8'h15,
  parameter int unsigned Timeout = 17360
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             mem_wr_en_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [7:0]       mem_din_o,
  input  logic [7:0]       mem_dout_i,
  output logic             busy_o
);

  localparam int unsigned TmoW = $clog2(Timeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(Timeout - 1);

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGetLen,
    StWrData,
    StSendAck,
    StSendNak,
    StRdReq,
    StRdWait,
    StRdSend
  } state_e;

  state_e           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             rx_ready_q, rx_ready_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             mem_wr_en_q, mem_wr_en_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]       mem_din_q, mem_din_d;

  logic rx_fire;
  logic tx_fire;
  logic tmo_hit;

  assign rx_fire = rx_valid_i & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready_i;
  // A byte arriving on the last allowed cycle wins over the timeout.
  assign tmo_hit = (tmo_q == TmoLast) & ~rx_fire;

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;

    if ((state_q inside {StGetAddr, StGetLen, StWrData}) && !rx_fire) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if ((rx_data_i == CmdWr) || (rx_data_i == CmdRd)) begin
            op_wr_d = (rx_data_i == CmdWr);
            state_d = StGetAddr;
          end else begin
            state_d    = StSendNak;
            tx_data_d  = NakByte;
            tx_valid_d = 1'b1;
          end
        end
      end

      StGetAddr: begin
        if (rx_fire) begin
          ptr_d   = AddrW'(rx_data_i);
          state_d = StGetLen;
        end else if (tmo_hit) begin
          state_d    = StSendNak;
          tx_data_d  = NakByte;
          tx_valid_d = 1'b1;
        end
      end

      StGetLen: begin
        if (rx_fire) begin
          cnt_d = (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
          if (op_wr_q) begin
            state_d = StWrData;
          end else begin
            state_d    = StRdReq;
            mem_addr_d = ptr_q;
          end
        end else if (tmo_hit) begin
          state_d    = StSendNak;
          tx_data_d  = NakByte;
          tx_valid_d = 1'b1;
        end
      end

      StWrData: begin
        if (rx_fire) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = ptr_q;
          mem_din_d   = rx_data_i;
          ptr_d       = ptr_q + 1'b1;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d    = StSendAck;
            tx_data_d  = AckByte;
            tx_valid_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d    = StSendNak;
          tx_data_d  = NakByte;
          tx_valid_d = 1'b1;
        end
      end

      StSendAck, StSendNak: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      StRdReq: begin
        state_d = StRdWait;
      end

      StRdWait: begin
        tx_data_d  = mem_dout_i;
        tx_valid_d = 1'b1;
        state_d    = StRdSend;
      end

      StRdSend: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          ptr_d      = ptr_q + 1'b1;
          cnt_d      = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = StIdle;
          end else begin
            state_d    = StRdReq;
            mem_addr_d = ptr_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Registered from the next state so rx_ready stays low while reset is held.
    rx_ready_d = state_d inside {StIdle, StGetAddr, StGetLen, StWrData};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      op_wr_q     <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_din_o   = mem_din_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Directed bench for uart_mem_ctrl: RAM model with one-cycle read latency, tx/write loggers,
// and hand-computed expected bytes.
module tb_uart_mem_ctrl;

  localparam int unsigned Timeout = 17360;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy;

  always #5 clk = ~clk;

  uart_mem_ctrl #(
    .Timeout(Timeout)
  ) dut (
    .clock_i    (clk),
    .reset_i    (reset),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .mem_wr_en_o(mem_wr_en),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout),
    .busy_o     (busy)
  );

  logic [7:0] ram [256];

  // Preloaded with addr ^ 5A so untouched locations are predictable.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  logic [7:0] tx_log[$];
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  int         stall_viol = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data_q = 8'h00;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (mem_wr_en) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_din);
    end
    if (stall_q && !(tx_valid && (tx_data == stall_data_q))) stall_viol <= stall_viol + 1;
    stall_q      <= tx_valid && !tx_ready && !reset;
    stall_data_q <= tx_data;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      tick();
      n++;
    end
    if (!rx_ready) check("rx_accept", 32'(rx_ready), 32'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, output int cyc);
    cyc = 0;
    while (tx_log.size() < target && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  // Expected RAM contents after the write bursts below.
  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hAA;
      8'h11:   return 8'hBB;
      8'h12:   return 8'hCC;
      8'hFE:   return 8'h11;
      8'hFF:   return 8'h22;
      8'h00:   return 8'h33;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  initial begin
    int base_tx;
    int base_wr;
    int cyc;
    int nerr;
    int n_hold;
    logic [7:0] wr_exp_a [3];
    logic [7:0] wr_exp_d [3];

    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Write burst 57 10 03 AA BB CC
    tx_ready = 1'b1;
    base_tx  = tx_log.size();
    base_wr  = wr_addr_log.size();
    send(8'h57); send(8'h10); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    wait_tx(base_tx + 1, 50, cyc);
    repeat (5) tick();
    check("wr1_count", 32'(wr_addr_log.size() - base_wr), 32'd3);
    wr_exp_a = '{8'h10, 8'h11, 8'h12};
    wr_exp_d = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      if (wr_addr_log.size() > base_wr + i) begin
        check("wr1_addr", 32'(wr_addr_log[base_wr+i]), 32'(wr_exp_a[i]));
        check("wr1_data", 32'(wr_data_log[base_wr+i]), 32'(wr_exp_d[i]));
      end
    end
    check("wr1_tx_count", 32'(tx_log.size() - base_tx), 32'd1);
    if (tx_log.size() > base_tx) check("wr1_ack", 32'(tx_log[base_tx]), 32'h06);
    check("wr1_busy_after", 32'(busy), 32'd0);

    // Read back 52 10 03
    base_tx = tx_log.size();
    base_wr = wr_addr_log.size();
    send(8'h52); send(8'h10); send(8'h03);
    wait_tx(base_tx + 3, 100, cyc);
    check("rd1_busy_drop", 32'(busy), 32'd0);
    repeat (10) tick();
    check("rd1_tx_count", 32'(tx_log.size() - base_tx), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (tx_log.size() > base_tx + i) check("rd1_byte", 32'(tx_log[base_tx+i]), 32'(wr_exp_d[i]));
    end
    check("rd1_no_write", 32'(wr_addr_log.size() - base_wr), 32'd0);

    // Wrapping write 57 FE 03 11 22 33, then read back
    base_tx = tx_log.size();
    base_wr = wr_addr_log.size();
    send(8'h57); send(8'hFE); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    wait_tx(base_tx + 1, 50, cyc);
    repeat (3) tick();
    wr_exp_a = '{8'hFE, 8'hFF, 8'h00};
    wr_exp_d = '{8'h11, 8'h22, 8'h33};
    check("wr2_count", 32'(wr_addr_log.size() - base_wr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (wr_addr_log.size() > base_wr + i) begin
        check("wr2_addr", 32'(wr_addr_log[base_wr+i]), 32'(wr_exp_a[i]));
        check("wr2_data", 32'(wr_data_log[base_wr+i]), 32'(wr_exp_d[i]));
      end
    end
    if (tx_log.size() > base_tx) check("wr2_ack", 32'(tx_log[base_tx]), 32'h06);
    base_tx = tx_log.size();
    send(8'h52); send(8'hFE); send(8'h03);
    wait_tx(base_tx + 3, 100, cyc);
    repeat (5) tick();
    check("rd2_tx_count", 32'(tx_log.size() - base_tx), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (tx_log.size() > base_tx + i) check("rd2_byte", 32'(tx_log[base_tx+i]), 32'(wr_exp_d[i]));
    end

    // Unknown command
    base_tx = tx_log.size();
    send(8'h41);
    wait_tx(base_tx + 1, 20, cyc);
    check("bad_cmd_busy", 32'(busy), 32'd0);
    check("bad_cmd_tx_count", 32'(tx_log.size() - base_tx), 32'd1);
    if (tx_log.size() > base_tx) check("bad_cmd_nak", 32'(tx_log[base_tx]), 32'h15);

    // Timeout inside a frame
    base_tx = tx_log.size();
    base_wr = wr_addr_log.size();
    send(8'h57); send(8'h20);
    wait_tx(base_tx + 1, Timeout + 50, cyc);
    check("tmo_cycles", 32'(cyc), 32'(Timeout + 1));
    if (tx_log.size() > base_tx) check("tmo_nak", 32'(tx_log[base_tx]), 32'h15);
    else check("tmo_tx_count", 32'(tx_log.size() - base_tx), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_no_write", 32'(wr_addr_log.size() - base_wr), 32'd0);

    // 256-byte read with tx_ready high one cycle in three
    base_tx  = tx_log.size();
    tx_ready = 1'b0;
    send(8'h52); send(8'h00); send(8'h00);
    cyc = 0;
    while (tx_log.size() < base_tx + 256 && cyc < 256 * 8) begin
      tx_ready = (cyc % 3 == 2);
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    repeat (6) tick();
    check("rd256_count", 32'(tx_log.size() - base_tx), 32'd256);
    nerr = 0;
    for (int i = 0; i < 256; i++) begin
      if (tx_log.size() > base_tx + i && tx_log[base_tx+i] !== exp_byte(8'(i))) nerr++;
    end
    check("rd256_mismatches", 32'(nerr), 32'd0);
    if (tx_log.size() >= base_tx + 256) begin
      check("rd256_first", 32'(tx_log[base_tx]), 32'h33);
      check("rd256_0x10", 32'(tx_log[base_tx+16]), 32'hAA);
      check("rd256_last", 32'(tx_log[base_tx+255]), 32'h22);
    end
    check("tx_stable_while_stalled", 32'(stall_viol), 32'd0);
    check("rd256_busy", 32'(busy), 32'd0);

    // Reset in the middle of a read burst
    base_tx = tx_log.size();
    base_wr = wr_addr_log.size();
    tx_ready = 1'b0;
    send(8'h52); send(8'h00); send(8'h00);
    cyc = 0;
    while (tx_log.size() < base_tx + 20 && cyc < 400) begin
      tx_ready = (cyc % 3 == 2);
      tick();
      cyc++;
    end
    check("mid_rst_progress", 32'(tx_log.size() - base_tx), 32'd20);
    tx_ready = 1'b0;
    reset    = 1'b1;
    tick();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    n_hold   = tx_log.size();
    tick();
    reset    = 1'b0;
    tx_ready = 1'b1;
    repeat (30) tick();
    check("mid_rst_no_more_tx", 32'(tx_log.size() - n_hold), 32'd0);
    check("mid_rst_no_write", 32'(wr_addr_log.size() - base_wr), 32'd0);
    check("mid_rst_rx_ready_back", 32'(rx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
